// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, next-PC
// source codes and the packed control-enable bundle.
package pipeline_ctrl_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_e;

   localparam logic [1:0] PCSRC_SEQ    = 2'd0;
   localparam logic [1:0] PCSRC_BRANCH = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   typedef struct packed {
      logic       pcWrite;
      logic [1:0] pcSrc;
      logic       ifidWrite;
      logic       ifidFlush;
      logic       idexFlush;
      logic       idexHold;
      logic       exmemFlush;
      logic       exmemHold;
      logic       memwbBubble;
   } ctl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle: hazard inputs from IF/ID, ID/EX, EX/MEM and the
// register enables, PC select and status counters going back.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   import pipeline_ctrl_pkg::*;

   logic [REG_W-1:0] idRs;
   logic [REG_W-1:0] idRt;
   logic             idUsesRt;
   logic             exMemRead;
   logic [REG_W-1:0] exRegDest;
   logic             memBranch;
   logic             memZero;
   logic             memJump;
   logic             memAccess;
   logic             memReady;

   logic             pcWrite;
   logic [1:0]       pcSrc;
   logic             ifidWrite;
   logic             ifidFlush;
   logic             idexFlush;
   logic             idexHold;
   logic             exmemFlush;
   logic             exmemHold;
   logic             memwbBubble;
   logic             memError;
   logic [CNT_W-1:0] stallCount;
   logic [CNT_W-1:0] flushCount;

   modport master (
      output idRs, idRt, idUsesRt, exMemRead, exRegDest,
             memBranch, memZero, memJump, memAccess, memReady,
      input  pcWrite, pcSrc, ifidWrite, ifidFlush, idexFlush, idexHold,
             exmemFlush, exmemHold, memwbBubble, memError, stallCount, flushCount
   );

   modport slave (
      input  idRs, idRt, idUsesRt, exMemRead, exRegDest,
             memBranch, memZero, memJump, memAccess, memReady,
      output pcWrite, pcSrc, ifidWrite, ifidFlush, idexFlush, idexHold,
             exmemFlush, exmemHold, memwbBubble, memError, stallCount, flushCount
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             resetN,
   input  logic             inc,
   output logic [CNT_W-1:0] value
);

   logic [CNT_W-1:0] value_q;

   always_ff @(posedge clock) begin
      if (!resetN)
         value_q <= '0;
      else if (inc && (value_q != '1))
         value_q <= value_q + CNT_W'(1);
   end

   assign value = value_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: load-use bubbles, MEM-stage redirects and
// data-memory wait freezes with a sticky timeout error.
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input logic                  clock,
   input logic                  resetN,
   pipeline_hazard_ctrl_if.slave bus
);

   localparam int              WC_W      = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W-1:0] WAIT_ONE  = WC_W'(1);
   localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

   state_e          state_q;
   logic [WC_W-1:0] waitCnt_q;
   logic            memError_q;

   logic mem_stall, freeze, redirect, load_use;
   ctl_t ctl;

   assign mem_stall = bus.memAccess & ~bus.memReady;
   assign freeze    = mem_stall | (state_q == ERROR);
   assign redirect  = (bus.memBranch & bus.memZero) | bus.memJump;
   assign load_use  = bus.exMemRead & (bus.exRegDest != '0) &
                      ((bus.exRegDest == bus.idRs) |
                       (bus.idUsesRt & (bus.exRegDest == bus.idRt)));

   always_ff @(posedge clock) begin
      if (!resetN) begin
         state_q    <= RUN;
         waitCnt_q  <= '0;
         memError_q <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (mem_stall) begin
                  state_q   <= MEM_WAIT;
                  waitCnt_q <= WAIT_ONE;
               end
            end
            MEM_WAIT: begin
               if (bus.memReady) begin
                  state_q   <= RUN;
                  waitCnt_q <= '0;
               end else if (waitCnt_q == WAIT_LAST) begin
                  state_q    <= ERROR;
                  memError_q <= 1'b1;
               end else begin
                  waitCnt_q <= waitCnt_q + WAIT_ONE;
               end
            end
            ERROR:   memError_q <= 1'b1;
            default: state_q    <= RUN;
         endcase
      end
   end

   // Priority: reset > freeze > redirect > load-use > normal flow.
   always_comb begin
      ctl = '{pcWrite: 1'b1, pcSrc: PCSRC_SEQ, ifidWrite: 1'b1, default: 1'b0};
      if (!resetN) begin
         ctl.pcWrite     = 1'b0;
         ctl.ifidWrite   = 1'b0;
         ctl.ifidFlush   = 1'b1;
         ctl.idexFlush   = 1'b1;
         ctl.exmemFlush  = 1'b1;
         ctl.memwbBubble = 1'b1;
      end else if (freeze) begin
         ctl.pcWrite     = 1'b0;
         ctl.ifidWrite   = 1'b0;
         ctl.idexHold    = 1'b1;
         ctl.exmemHold   = 1'b1;
         ctl.memwbBubble = 1'b1;
      end else if (redirect) begin
         ctl.pcSrc      = bus.memJump ? PCSRC_JUMP : PCSRC_BRANCH;
         ctl.ifidFlush  = 1'b1;
         ctl.idexFlush  = 1'b1;
         ctl.exmemFlush = 1'b1;
      end else if (load_use) begin
         ctl.pcWrite   = 1'b0;
         ctl.ifidWrite = 1'b0;
         ctl.idexFlush = 1'b1;
      end
   end

   assign bus.pcWrite     = ctl.pcWrite;
   assign bus.pcSrc       = ctl.pcSrc;
   assign bus.ifidWrite   = ctl.ifidWrite;
   assign bus.ifidFlush   = ctl.ifidFlush;
   assign bus.idexFlush   = ctl.idexFlush;
   assign bus.idexHold    = ctl.idexHold;
   assign bus.exmemFlush  = ctl.exmemFlush;
   assign bus.exmemHold   = ctl.exmemHold;
   assign bus.memwbBubble = ctl.memwbBubble;
   assign bus.memError    = memError_q;

   // A redirect swallowed by a freeze is not counted until it is actually taken.
   logic stall_inc, flush_inc;
   assign stall_inc = freeze | (load_use & ~redirect);
   assign flush_inc = redirect & ~freeze;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clock (clock),
      .resetN(resetN),
      .inc   (stall_inc),
      .value (bus.stallCount)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clock (clock),
      .resetN(resetN),
      .inc   (flush_inc),
      .value (bus.flushCount)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences
// and a randomized run against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

   localparam int TMO  = 4;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct packed {
      logic       pcWrite;
      logic [1:0] pcSrc;
      logic       ifidWrite;
      logic       ifidFlush;
      logic       idexFlush;
      logic       idexHold;
      logic       exmemFlush;
      logic       exmemHold;
      logic       memwbBubble;
   } ctl_t;

   typedef struct packed {
      logic [4:0] idRs;
      logic [4:0] idRt;
      logic       idUsesRt;
      logic       exMemRead;
      logic [4:0] exRegDest;
      logic       memBranch;
      logic       memZero;
      logic       memJump;
      logic       memAccess;
      logic       memReady;
   } in_t;

   typedef struct {
      string nm;
      in_t   i;
      ctl_t  e;
   } vec_t;

   localparam ctl_t C_NORM = 10'b1_00_1_000000;
   localparam ctl_t C_RST  = 10'b0_00_0_110101;
   localparam ctl_t C_FRZ  = 10'b0_00_0_001011;
   localparam ctl_t C_LU   = 10'b0_00_0_010000;
   localparam ctl_t C_BR   = 10'b1_01_1_110100;
   localparam ctl_t C_JMP  = 10'b1_10_1_110100;
   localparam in_t  IDLE   = '0;

   logic clock;
   logic resetN;
   int   n_pass = 0;
   int   n_tot  = 0;

   pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clock (clock),
      .resetN(resetN),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic in_t mk(input logic [4:0] rs, rt, input logic ut, mr,
                              input logic [4:0] rd, input logic br, z, j, ma, rdy);
      in_t v;
      v = '{rs, rt, ut, mr, rd, br, z, j, ma, rdy};
      return v;
   endfunction

   task automatic apply(input in_t v);
      bus.idRs      = v.idRs;
      bus.idRt      = v.idRt;
      bus.idUsesRt  = v.idUsesRt;
      bus.exMemRead = v.exMemRead;
      bus.exRegDest = v.exRegDest;
      bus.memBranch = v.memBranch;
      bus.memZero   = v.memZero;
      bus.memJump   = v.memJump;
      bus.memAccess = v.memAccess;
      bus.memReady  = v.memReady;
   endtask

   function automatic ctl_t obs();
      ctl_t c;
      c = {bus.pcWrite, bus.pcSrc, bus.ifidWrite, bus.ifidFlush, bus.idexFlush,
           bus.idexHold, bus.exmemFlush, bus.exmemHold, bus.memwbBubble};
      return c;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      apply(IDLE);
      tick();
      resetN = 1'b1;
   endtask

   // Reference model: spec rules as plain predicates plus a count of
   // consecutive not-ready cycles since the access began.
   function automatic bit f_redir(input in_t v);
      return (v.memBranch && v.memZero) || v.memJump;
   endfunction

   function automatic bit f_lu(input in_t v);
      return v.exMemRead && (v.exRegDest != 0) &&
             ((v.exRegDest == v.idRs) || (v.idUsesRt && (v.exRegDest == v.idRt)));
   endfunction

   function automatic ctl_t ref_ctl(input bit rstn, input bit err, input in_t v);
      if (!rstn) return C_RST;
      if (err || (v.memAccess && !v.memReady)) return C_FRZ;
      if (f_redir(v)) return v.memJump ? C_JMP : C_BR;
      if (f_lu(v)) return C_LU;
      return C_NORM;
   endfunction

   vec_t tbl[11];

   initial begin
      int m_nr, m_stall, m_flush;
      bit m_err, rstn, frz;
      in_t v;

      tbl[0]  = '{"normal",      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), C_NORM};
      tbl[1]  = '{"lu_rs",       mk(8, 3, 0, 1, 8, 0, 0, 0, 0, 0), C_LU};
      tbl[2]  = '{"lu_r0",       mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0), C_NORM};
      tbl[3]  = '{"lu_rt",       mk(1, 5, 1, 1, 5, 0, 0, 0, 0, 0), C_LU};
      tbl[4]  = '{"rt_unused",   mk(1, 5, 0, 1, 5, 0, 0, 0, 0, 0), C_NORM};
      tbl[5]  = '{"no_memread",  mk(8, 8, 1, 0, 8, 0, 0, 0, 0, 0), C_NORM};
      tbl[6]  = '{"br_over_lu",  mk(8, 3, 0, 1, 8, 1, 1, 0, 0, 0), C_BR};
      tbl[7]  = '{"br_not_tkn",  mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), C_NORM};
      tbl[8]  = '{"jmp_over_br", mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0), C_JMP};
      tbl[9]  = '{"jmp",         mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_JMP};
      tbl[10] = '{"mem_rdy_1st", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), C_NORM};

      resetN = 1'b0;
      apply(IDLE);
      tick();
      chk("reset_ctl", 32'(obs()), 32'(C_RST));
      chk("reset_cnt", {bus.memError, bus.stallCount, bus.flushCount}, '0);
      resetN = 1'b1;

      foreach (tbl[k]) begin
         apply(tbl[k].i);
         #1;
         chk(tbl[k].nm, 32'(obs()), 32'(tbl[k].e));
         tick();
      end
      apply(IDLE);
      #1;
      chk("tbl_stall_cnt", 32'(bus.stallCount), 32'd2);
      chk("tbl_flush_cnt", 32'(bus.flushCount), 32'd3);

      // 3-cycle memory wait then ready
      do_reset();
      for (int c = 0; c < 3; c++) begin
         apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
         #1;
         chk("wait_frz", 32'(obs()), 32'(C_FRZ));
         tick();
      end
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      #1;
      chk("wait_release", 32'(obs()), 32'(C_NORM));
      tick();
      apply(IDLE);
      #1;
      chk("wait_stall_cnt", 32'(bus.stallCount), 32'd3);
      chk("wait_back_run", {obs(), bus.memError}, {C_NORM, 1'b0});

      // redirect held off by a 2-cycle freeze
      do_reset();
      for (int c = 0; c < 2; c++) begin
         apply(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
         #1;
         chk("defer_frz", 32'(obs()), 32'(C_FRZ));
         tick();
      end
      apply(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 1));
      #1;
      chk("defer_redir", 32'(obs()), 32'(C_BR));
      tick();
      apply(IDLE);
      #1;
      chk("defer_cnts", {bus.stallCount, bus.flushCount}, {4'd2, 4'd1});

      // timeout into sticky ERROR
      do_reset();
      for (int c = 0; c < TMO; c++) begin
         apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
         #1;
         chk("tmo_frz", {obs(), bus.memError}, {C_FRZ, 1'b0});
         tick();
      end
      apply(IDLE);
      #1;
      chk("tmo_error", {obs(), bus.memError}, {C_FRZ, 1'b1});
      tick();
      apply(mk(8, 0, 0, 1, 8, 1, 1, 0, 0, 1));
      #1;
      chk("tmo_sticky", {obs(), bus.memError}, {C_FRZ, 1'b1});
      tick();
      resetN = 1'b0;
      #1;
      chk("tmo_rst_ctl", 32'(obs()), 32'(C_RST));
      tick();
      resetN = 1'b1;
      apply(IDLE);
      #1;
      chk("tmo_cleared", {obs(), bus.memError, bus.stallCount}, {C_NORM, 1'b0, 4'd0});

      // reset in the middle of a wait
      do_reset();
      for (int c = 0; c < 2; c++) begin
         apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
         tick();
      end
      resetN = 1'b0;
      #1;
      chk("midwait_rst", 32'(obs()), 32'(C_RST));
      tick();
      resetN = 1'b1;
      for (int c = 0; c < TMO - 1; c++) begin
         apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
         #1;
         chk("midwait_rewait", {obs(), bus.memError}, {C_FRZ, 1'b0});
         tick();
      end
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      #1;
      chk("midwait_done", {obs(), bus.memError}, {C_NORM, 1'b0});
      tick();
      apply(IDLE);
      #1;
      chk("midwait_stall", 32'(bus.stallCount), 32'd3);

      // stall counter saturation
      do_reset();
      apply(mk(8, 0, 0, 1, 8, 0, 0, 0, 0, 0));
      repeat (CMAX + 5) tick();
      #1;
      chk("sat_stall", {bus.stallCount, bus.flushCount}, {4'(CMAX), 4'd0});

      // randomized run against the model
      do_reset();
      m_nr = 0; m_err = 0; m_stall = 0; m_flush = 0;
      for (int c = 0; c < 800; c++) begin
         v = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) < 3));
         rstn = ($urandom_range(0, 39) != 0);
         resetN = rstn;
         apply(v);
         #1;
         chk("rand", {obs(), bus.memError, bus.stallCount, bus.flushCount},
             {ref_ctl(rstn, m_err, v), m_err, 4'(m_stall), 4'(m_flush)});
         if (!rstn) begin
            m_nr = 0; m_err = 0; m_stall = 0; m_flush = 0;
         end else begin
            frz = m_err || (v.memAccess && !v.memReady);
            if (frz || (f_lu(v) && !f_redir(v))) begin
               if (m_stall < CMAX) m_stall++;
            end else if (f_redir(v)) begin
               if (m_flush < CMAX) m_flush++;
            end
            if (!m_err) begin
               if (m_nr == 0) begin
                  if (v.memAccess && !v.memReady) m_nr = 1;
               end else if (v.memReady) begin
                  m_nr = 0;
               end else begin
                  m_nr++;
                  if (m_nr == TMO) m_err = 1;
               end
            end
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
